i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C responder (slave), the opposite end of the I2C controller that drives the OLED panel on io_sda/io_scl.
- Lets an external host write and read a small register/character space, for example the text buffer's 64 cells, over SDA/SCL.
- Sits beside the bus and drives a simple synchronous register port.
- Open-drain only: never drives SCL; pulls SDA low through sda_oe.

Parameters:
- DEV_ADDR, 7'h42, 7-bit target address matched on the address byte.
- PTR_W, 6, width of the internal register pointer; register space is 2^PTR_W bytes.

Ports:
- clk  in  1  system clock; must be at least 20× the SCL frequency.
- reset  in  1  synchronous, active-low reset.
- scl_in  in  1  raw SCL pad input (asynchronous).
- sda_in  in  1  raw SDA pad input (asynchronous).
- sda_oe  out  1  1 = pull SDA low (pad tristate enable); 0 = release.
- reg_addr  out  PTR_W  register address for the current access.
- reg_wdata  out  8  write data.
- reg_wen  out  1  one-cycle write strobe.
- reg_ren  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data; valid exactly 1 clk after reg_ren.
- busy  out  1  high from a START addressing this device until the following STOP.

Behaviour:
- Reset (reset==0 at posedge clk): state IDLE, sda_oe=0, reg_wen=0, reg_ren=0, busy=0, ptr=0, reg_addr=0, reg_wdata=0.
- Input conditioning: SCL and SDA each pass a 2-flop synchronizer; rise/fall detected from the synchronized and previous samples. Bus-event latency is 3 clk from pad.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are honoured in every state.
  - START (including repeated START) -> ADDR, bit counter cleared.
  - STOP -> IDLE, sda_oe=0, busy=0.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first on SCL rise. After the 8th rise:
    - addr[7:1]==DEV_ADDR -> ACK_ADDR, with direction taken from bit0.
    - otherwise -> IGNORE; sda_oe stays 0 until the next START/STOP.
  - ACK_ADDR: on SCL fall, sda_oe=1 for one SCL period; released on the next SCL fall.
    - Write direction -> WR_PTR.
    - Read direction -> RD_LOAD.
  - WR_PTR: first data byte after a write address loads ptr (low PTR_W bits; upper bits ignored) -> ACK_DATA.
  - WR_DATA: after 8 bits, reg_addr=ptr, reg_wdata=byte, reg_wen pulses 1 clk on the 8th SCL rise + 1 clk. Then ptr=ptr+1 mod 2^PTR_W -> ACK_DATA.
  - ACK_DATA: drive ACK as in ACK_ADDR, then -> WR_DATA. Every received byte is ACKed; there is no NACK on write.
  - RD_LOAD: reg_ren with reg_addr=ptr. Next clk, capture reg_rdata into the shift register and ptr=ptr+1 mod 2^PTR_W. Then drive bit7 (sda_oe = ~bit) -> RD_DATA. The whole load completes while SCL is still low.
  - RD_DATA: change SDA only on SCL fall (1 clk after the detected fall). After the 8th fall, release SDA -> RD_ACK.
  - RD_ACK: sample SDA on SCL rise.
    - 0 (ACK) -> RD_LOAD on the next SCL fall.
    - 1 (NACK) -> IGNORE until STOP/START.
- Simultaneous events: START/STOP detection has priority over SCL-edge processing in the same clk.
- Reset mid-transfer releases SDA immediately, with no strobe generated.
- Pointer is retained across transactions; it is cleared only by reset.

Optional Feature:
- Macro: I2C_TARGET_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter after each synchronizer. Pulses of 1 clk or less are rejected; bus-event latency becomes 5 clk.
- Undefined: no filter; latency stays 3 clk.

Decomposition:
- Shared package/header i2c_pkg.vh:
  - state encodings (IDLE, ADDR, ACK_ADDR, WR_PTR, WR_DATA, ACK_DATA, RD_LOAD, RD_DATA, RD_ACK, IGNORE);
  - I2C_DIR_WRITE=0 and I2C_DIR_READ=1;
  - ACK=0 and NACK=1.
- One natural sub-module, i2c_line_sync: synchronizer, optional filter and edge detect. Instantiated once each for SCL and SDA.

Test Plan:
- Addressed write: START, 0x84, 0x05, 0x41, STOP -> three ACKs; reg_wen exactly once with reg_addr=5, reg_wdata=0x41; final ptr=6.
- Wrong address: START, 0xA0, 0x00, STOP -> sda_oe never asserted; no reg_wen or reg_ren; busy stays 0.
- Read with pointer wrap: write ptr 0x3F, repeated START, 0x85, host ACKs byte 1 and NACKs byte 2, register file returns 0x11@0x3F and 0x22@0x00 -> SDA carries 0x11 then 0x22; reg_ren asserted at addresses 0x3F then 0x00.
- Early STOP: STOP inserted after 4 data bits of a write byte -> no reg_wen; state IDLE; the next transaction works normally.
- Reset mid-ACK: reset low while sda_oe=1 -> sda_oe=0 the next clk and all outputs at reset values.
- With I2C_TARGET_GLITCH_FILTER_EN: 1-clk low glitch on SCL during a data bit -> no extra bit shifted; the byte is received correctly.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared state encoding, bus direction / acknowledge constants
// and the majority-vote helper used by the optional glitch filter
// (I2C_TARGET_GLITCH_FILTER_EN).
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_WR_PTR,
    ST_WR_DATA,
    ST_ACK_DATA,
    ST_RD_LOAD,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  localparam logic I2C_DIR_WRITE = 1'b0;
  localparam logic I2C_DIR_READ  = 1'b1;
  localparam logic ACK           = 1'b0;
  localparam logic NACK          = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_target_if.sv
// i2c_target_if: pad-side I2C lines plus the synchronous register port of the
// I2C target. The slave modport is the target's view, master the host/system view.
interface i2c_target_if #(
  parameter int PTR_W = 6
);
  logic             scl_in;
  logic             sda_in;
  logic             sda_oe;
  logic [PTR_W-1:0] reg_addr;
  logic [7:0]       reg_wdata;
  logic             reg_wen;
  logic             reg_ren;
  logic [7:0]       reg_rdata;
  logic             busy;

  modport slave (
    input  scl_in, sda_in, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_wen, reg_ren, busy
  );

  modport master (
    output scl_in, sda_in, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_wen, reg_ren, busy
  );
endinterface

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: brings one asynchronous I2C pad into the clk domain and
// reports its level plus rise/fall pulses. With I2C_TARGET_GLITCH_FILTER_EN
// a 3-sample majority filter rejects pulses of one clk or less (latency 5 clk
// instead of 3). Lines reset to the idle-high bus level.
module i2c_line_sync
  import i2c_target_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic pad_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  // Two-flop synchronizer, two older samples, registered majority vote.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 2'b11;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= pad_in;
      sync_q <= meta_q;
      hist_q <= {hist_q[0], sync_q};
      filt_q <= maj3(sync_q, hist_q[0], hist_q[1]);
      prev_q <= filt_q;
    end
  end

  assign level = filt_q;
`else
  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= pad_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
`endif

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: open-drain I2C responder exposing a 2^PTR_W byte register space
// through a one-cycle strobe register port. First written byte sets the
// pointer, later bytes write and auto-increment; reads auto-increment too.
// Optional macro: I2C_TARGET_GLITCH_FILTER_EN (majority filter on SCL/SDA).
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         PTR_W    = 6
)(
  input logic          clk,
  input logic          reset,
  i2c_target_if.slave  bus
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;
  logic start_evt, stop_evt;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             dir_q, dir_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sda_oe_q, sda_oe_d;
  logic [PTR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]       reg_wdata_q, reg_wdata_d;
  logic             reg_wen_q, reg_wen_d;
  logic             reg_ren_q, reg_ren_d;
  logic             busy_q, busy_d;

  i2c_line_sync u_scl_sync (
    .clk    (clk),
    .reset  (reset),
    .pad_in (bus.scl_in),
    .level  (scl_level),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk    (clk),
    .reset  (reset),
    .pad_in (bus.sda_in),
    .level  (sda_level),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  assign start_evt = sda_fall & scl_level;
  assign stop_evt  = sda_rise & scl_level;

  // State register and all registered outputs; reset releases SDA at once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      dir_q       <= I2C_DIR_WRITE;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wen_q   <= 1'b0;
      reg_ren_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      dir_q       <= dir_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wen_q   <= reg_wen_d;
      reg_ren_q   <= reg_ren_d;
      busy_q      <= busy_d;
    end
  end

  // Next state: START/STOP override everything, otherwise act on SCL edges.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    dir_d       = dir_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wen_d   = 1'b0;
    reg_ren_d   = 1'b0;
    busy_d      = busy_q;

    if (start_evt) begin
      state_d  = ST_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (stop_evt) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_level};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (shift_d[7:1] == DEV_ADDR) begin
                state_d = ST_ACK_ADDR;
                dir_d   = shift_d[0];
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end
        ST_ACK_ADDR, ST_ACK_DATA: begin
          // sda_oe low on a fall means the ACK slot is starting, high means it ends.
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              if (state_q == ST_ACK_DATA)
                state_d = ST_WR_DATA;
              else if (dir_q == I2C_DIR_WRITE)
                state_d = ST_WR_PTR;
              else
                state_d = ST_RD_LOAD;
            end
          end
        end
        ST_WR_PTR, ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_level};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d = ST_ACK_DATA;
              if (state_q == ST_WR_PTR) begin
                ptr_d = shift_d[PTR_W-1:0];
              end else begin
                reg_addr_d  = ptr_q;
                reg_wdata_d = shift_d;
                reg_wen_d   = 1'b1;
                ptr_d       = ptr_q + 1'b1;
              end
            end
          end
        end
        ST_RD_LOAD: begin
          // cnt sequences: issue strobe, wait for the register port, capture.
          case (cnt_q)
            3'd0: begin
              reg_ren_d  = 1'b1;
              reg_addr_d = ptr_q;
              cnt_d      = 3'd1;
            end
            3'd1: cnt_d = 3'd2;
            default: begin
              shift_d  = bus.reg_rdata;
              ptr_d    = ptr_q + 1'b1;
              sda_oe_d = ~bus.reg_rdata[7];
              cnt_d    = '0;
              state_d  = ST_RD_DATA;
            end
          endcase
        end
        ST_RD_DATA: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = ST_RD_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
              cnt_d    = cnt_q + 3'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_level == ACK)
              cnt_d = 3'd1;
            else
              state_d = ST_IGNORE;
          end else if (scl_fall && cnt_q == 3'd1) begin
            cnt_d   = '0;
            state_d = ST_RD_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_wen   = reg_wen_q;
  assign bus.reg_ren   = reg_ren_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C host, a small register file behind the
// register port, and a transaction-level model (pointer, memory image and
// expected strobe queues) that the DUT is checked against.
module tb_i2c_target;

  localparam int Q = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic host_scl = 1'b1;
  logic host_sda = 1'b1;

  i2c_target_if #(.PTR_W(6)) bus ();

  i2c_target #(.DEV_ADDR(7'h42), .PTR_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.scl_in = host_scl;
  assign bus.sda_in = host_sda & ~bus.sda_oe;

  int total = 0;
  int bad = 0;

  // Model state
  int         ptr_m = 0;
  logic       busy_m = 1'b0;
  logic [7:0] model_mem [64];
  logic [13:0] wq [$];
  logic [5:0]  rq [$];
  logic        silent = 1'b0;

  // Observation log used by the literal checks
  int         wen_count = 0;
  logic [5:0] last_waddr = '0;
  logic [7:0] last_wdata = '0;
  logic [5:0] ren_log [$];

  // Register file behind the port
  logic [7:0]  env_mem [64];
  logic [63:0] written = '0;

  function automatic logic [7:0] initVal(input int a);
    return 8'((a * 29 + 7) & 255);
  endfunction

  always @(posedge clk) begin
    if (bus.reg_wen) begin
      env_mem[bus.reg_addr] <= bus.reg_wdata;
      written[bus.reg_addr] <= 1'b1;
    end
    if (bus.reg_ren)
      bus.reg_rdata <= written[bus.reg_addr] ? env_mem[bus.reg_addr] : initVal(int'(bus.reg_addr));
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: every strobe must match the next expected one; a silent
  // (non-addressed) transaction must never see SDA pulled.
  always @(negedge clk) begin
    logic [13:0] we;
    logic [5:0]  re;
    if (bus.reg_wen) begin
      wen_count++;
      last_waddr = bus.reg_addr;
      last_wdata = bus.reg_wdata;
      if (wq.size() == 0) begin
        checkOutput("wen_expected", 32'(wq.size()), 32'd1);
      end else begin
        we = wq.pop_front();
        checkOutput("wen_addr", 32'(bus.reg_addr), 32'(we[13:8]));
        checkOutput("wen_data", 32'(bus.reg_wdata), 32'(we[7:0]));
      end
    end
    if (bus.reg_ren) begin
      ren_log.push_back(bus.reg_addr);
      if (rq.size() == 0) begin
        checkOutput("ren_expected", 32'(rq.size()), 32'd1);
      end else begin
        re = rq.pop_front();
        checkOutput("ren_addr", 32'(bus.reg_addr), 32'(re));
      end
    end
    if (silent)
      checkOutput("silent_sda_oe", 32'(bus.sda_oe), 32'd0);
  end

  task automatic waitq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bitCycle(input logic b, output logic s);
    host_sda = b;
    waitq();
    host_scl = 1'b1;
    waitq();
    s = host_sda & ~bus.sda_oe;
    waitq();
    host_scl = 1'b0;
    waitq();
  endtask

  task automatic bitCycleGlitch(input logic b, output logic s);
    host_sda = b;
    waitq();
    host_scl = 1'b1;
    repeat (Q / 2) @(negedge clk);
    host_scl = 1'b0;
    @(negedge clk);
    host_scl = 1'b1;
    repeat (Q / 2) @(negedge clk);
    s = host_sda & ~bus.sda_oe;
    waitq();
    host_scl = 1'b0;
    waitq();
  endtask

  task automatic startCond();
    host_sda = 1'b1;
    waitq();
    host_scl = 1'b1;
    waitq();
    host_sda = 1'b0;
    waitq();
    host_scl = 1'b0;
    waitq();
  endtask

  task automatic stopCond();
    host_sda = 1'b0;
    waitq();
    host_scl = 1'b1;
    waitq();
    host_sda = 1'b1;
    waitq();
    waitq();
  endtask

  task automatic writeByte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bitCycle(b[i], s);
    bitCycle(1'b1, s);
    acked = (s == 1'b0);
  endtask

  task automatic readByte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bitCycle(1'b1, s);
      d[i] = s;
    end
    bitCycle(nack, s);
  endtask

  task automatic doWrite(input logic [7:0] addr_byte, input logic [7:0] data [8], input int n);
    logic addressed, ack;
    addressed = (addr_byte[7:1] == 7'h42);
    if (!addressed) silent = 1'b1;
    startCond();
    writeByte(addr_byte, ack);
    checkOutput("wr_addr_ack", 32'(ack), 32'(addressed));
    busy_m = busy_m | addressed;
    checkOutput("busy_after_addr", 32'(bus.busy), 32'(busy_m));
    for (int k = 0; k < n; k++) begin
      if (addressed) begin
        if (k == 0) begin
          ptr_m = data[0] % 64;
        end else begin
          wq.push_back({6'(ptr_m), data[k]});
          model_mem[ptr_m] = data[k];
          ptr_m = (ptr_m + 1) % 64;
        end
      end
      writeByte(data[k], ack);
      checkOutput("wr_data_ack", 32'(ack), 32'(addressed));
    end
  endtask

  task automatic doRead(input logic [7:0] addr_byte, input int n, output logic [7:0] got [4]);
    logic addressed, ack;
    logic [7:0] exp [4];
    addressed = (addr_byte[7:1] == 7'h42);
    if (!addressed) silent = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (addressed) begin
        rq.push_back(6'(ptr_m));
        exp[k] = model_mem[ptr_m];
        ptr_m = (ptr_m + 1) % 64;
      end else begin
        exp[k] = 8'hFF;
      end
    end
    startCond();
    writeByte(addr_byte, ack);
    checkOutput("rd_addr_ack", 32'(ack), 32'(addressed));
    busy_m = busy_m | addressed;
    checkOutput("busy_after_addr", 32'(bus.busy), 32'(busy_m));
    for (int k = 0; k < n; k++) begin
      readByte(k == n - 1, got[k]);
      checkOutput("rd_data", 32'(got[k]), 32'(exp[k]));
    end
  endtask

  task automatic finishTxn();
    stopCond();
    silent = 1'b0;
    busy_m = 1'b0;
    checkOutput("busy_after_stop", 32'(bus.busy), 32'd0);
    checkOutput("wq_drained", 32'(wq.size()), 32'd0);
    checkOutput("rq_drained", 32'(rq.size()), 32'd0);
  endtask

  task automatic applyStimulus(input int kind);
    logic [7:0] d [8];
    logic [7:0] got [4];
    logic [6:0] a7;
    int n;
    n = $urandom_range(1, 4);
    for (int k = 0; k < 8; k++) d[k] = 8'($urandom);
    a7 = 7'($urandom_range(0, 127));
    if (a7 == 7'h42) a7 = 7'h13;
    case (kind)
      0, 1: doWrite(8'h84, d, n);
      2: doRead(8'h85, n, got);
      default: begin
        if ($urandom_range(0, 1) == 0) doWrite({a7, 1'b0}, d, n);
        else doRead({a7, 1'b1}, n, got);
      end
    endcase
    finishTxn();
  endtask

  initial begin
    #950000;
    $display("[TB] FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] d [8];
    logic [7:0] got [4];
    int wen_base, ren_base, i;

    for (int k = 0; k < 64; k++) model_mem[k] = initVal(k);

    // Reset state
    repeat (4) @(negedge clk);
    checkOutput("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_wen", 32'(bus.reg_wen), 32'd0);
    checkOutput("rst_ren", 32'(bus.reg_ren), 32'd0);
    checkOutput("rst_addr", 32'(bus.reg_addr), 32'd0);
    checkOutput("rst_wdata", 32'(bus.reg_wdata), 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Addressed write: pointer 5, data 0x41
    $display("[TB] addressed write");
    wen_base = wen_count;
    d[0] = 8'h05; d[1] = 8'h41;
    doWrite(8'h84, d, 2);
    finishTxn();
    checkOutput("lit_wen_count", 32'(wen_count - wen_base), 32'd1);
    checkOutput("lit_wen_addr", 32'(last_waddr), 32'h05);
    checkOutput("lit_wen_data", 32'(last_wdata), 32'h41);
    checkOutput("lit_model_ptr", 32'(ptr_m), 32'd6);
    doRead(8'h85, 1, got);
    finishTxn();
    checkOutput("lit_ren_after_write", 32'(ren_log[ren_log.size() - 1]), 32'h06);

    // Wrong address: nothing may happen
    $display("[TB] wrong address");
    wen_base = wen_count;
    ren_base = ren_log.size();
    d[0] = 8'h00;
    doWrite(8'hA0, d, 1);
    finishTxn();
    checkOutput("lit_wrong_wen", 32'(wen_count - wen_base), 32'd0);
    checkOutput("lit_wrong_ren", 32'(ren_log.size() - ren_base), 32'd0);

    // Read with pointer wrap
    $display("[TB] read with wrap");
    d[0] = 8'h3F; d[1] = 8'h11; d[2] = 8'h22;
    doWrite(8'h84, d, 3);
    finishTxn();
    doWrite(8'h84, d, 1);
    doRead(8'h85, 2, got);
    finishTxn();
    checkOutput("lit_rd_byte0", 32'(got[0]), 32'h11);
    checkOutput("lit_rd_byte1", 32'(got[1]), 32'h22);
    checkOutput("lit_ren_0", 32'(ren_log[ren_log.size() - 2]), 32'h3F);
    checkOutput("lit_ren_1", 32'(ren_log[ren_log.size() - 1]), 32'h00);

    // Early STOP after four data bits
    $display("[TB] early stop");
    wen_base = wen_count;
    d[0] = 8'h20;
    doWrite(8'h84, d, 1);
    begin
      logic s;
      bitCycle(1'b1, s);
      bitCycle(1'b0, s);
      bitCycle(1'b1, s);
      bitCycle(1'b1, s);
    end
    finishTxn();
    checkOutput("lit_early_stop_wen", 32'(wen_count - wen_base), 32'd0);
    doRead(8'h85, 1, got);
    finishTxn();
    checkOutput("lit_ren_after_early_stop", 32'(ren_log[ren_log.size() - 1]), 32'h20);

    // Reset while the address ACK is being driven
    $display("[TB] reset mid-ack");
    begin
      logic s;
      startCond();
      for (int b = 7; b >= 0; b--) bitCycle(b == 7 || b == 2, s);
      host_sda = 1'b1;
      i = 0;
      while (i < 40 && !bus.sda_oe) begin
        @(negedge clk);
        i++;
      end
      checkOutput("ack_before_reset", 32'(bus.sda_oe), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_sda_oe", 32'(bus.sda_oe), 32'd0);
      checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("mid_rst_wen", 32'(bus.reg_wen), 32'd0);
      checkOutput("mid_rst_ren", 32'(bus.reg_ren), 32'd0);
      checkOutput("mid_rst_addr", 32'(bus.reg_addr), 32'd0);
      checkOutput("mid_rst_wdata", 32'(bus.reg_wdata), 32'd0);
      reset = 1'b1;
      ptr_m = 0;
      busy_m = 1'b0;
      waitq();
      host_scl = 1'b1;
      waitq();
    end
    doRead(8'h85, 1, got);
    finishTxn();
    checkOutput("lit_ren_after_reset", 32'(ren_log[ren_log.size() - 1]), 32'h00);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // One-clk SCL glitch inside a data bit must not shift an extra bit
    $display("[TB] scl glitch");
    begin
      logic s, ack;
      logic [7:0] v;
      v = 8'h5A;
      d[0] = 8'h10;
      doWrite(8'h84, d, 1);
      wq.push_back({6'(ptr_m), v});
      model_mem[ptr_m] = v;
      ptr_m = (ptr_m + 1) % 64;
      for (int b = 7; b >= 0; b--) begin
        if (b == 3) bitCycleGlitch(v[b], s);
        else bitCycle(v[b], s);
      end
      bitCycle(1'b1, s);
      ack = (s == 1'b0);
      checkOutput("glitch_ack", 32'(ack), 32'd1);
      finishTxn();
      checkOutput("lit_glitch_data", 32'(last_wdata), 32'h5A);
      checkOutput("lit_glitch_addr", 32'(last_waddr), 32'h10);
    end
`endif

    // Randomized traffic
    $display("[TB] random traffic");
    for (int t = 0; t < 18; t++) applyStimulus($urandom_range(0, 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
